// File: rtl/ysyx_25040105_exu_mc_if.sv
// ysyx_25040105_exu_mc_if: IDU-side and downstream handshake bundle of the multi-cycle EXU
interface ysyx_25040105_exu_mc_if #(
    parameter int XLEN = 32
);
    logic            in_valid, in_ready, alu_src, flush, out_valid, out_ready, busy;
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm, alu_result;
    logic [4:0]      alu_op;
    modport master (
        output in_valid, pc, rs1_data, rs2_data, imm, alu_op, alu_src, flush, out_ready,
        input  in_ready, out_valid, alu_result, busy
    );
    modport slave (
        input  in_valid, pc, rs1_data, rs2_data, imm, alu_op, alu_src, flush, out_ready,
        output in_ready, out_valid, alu_result, busy
    );
endinterface

// File: rtl/ysyx_25040105_exu_mc.sv
// ysyx_25040105_exu_mc: multi-cycle RV32IM execute unit with iterative multiply/divide
module ysyx_25040105_exu_mc #(
    parameter int XLEN = 32
) (
    input logic                  clk,
    input logic                  rst,
    ysyx_25040105_exu_mc_if.slave io
);
    localparam int SHW = $clog2(XLEN);
    typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;
    state_t            state;
    logic [XLEN-1:0]   op1, op2, pc_r, mplier, alu, a_abs, b_abs, q_next, r_next, rsub, mul_res, div_res;
    logic [4:0]        op;
    logic [SHW-1:0]    cnt;
    logic [2*XLEN-1:0] acc, mcand, addend, acc_next;
    logic [XLEN:0]     rtry;
    logic              sa, sb, ge, neg_q;
    assign io.in_ready = state == IDLE;
    assign io.busy     = state != IDLE;
    always_comb begin
        case (op)
            5'd0:    alu = op1 + op2;
            5'd1:    alu = op1 - op2;
            5'd2:    alu = op1 << op2[SHW-1:0];
            5'd3:    alu = op1 >> op2[SHW-1:0];
            5'd4:    alu = pc_r + op2;
            5'd5:    alu = $signed(op1) >>> op2[SHW-1:0];
            5'd6:    alu = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            5'd7:    alu = {{(XLEN-1){1'b0}}, op1 < op2};
            5'd8:    alu = op1 ^ op2;
            5'd9:    alu = op1 | op2;
            5'd10:   alu = op1 & op2;
            5'd11:   alu = op2;
            default: alu = '0;
        endcase
    end
    // sa/sb: operand is treated as signed by this op and is negative
    assign sa       = (op inside {5'd17, 5'd18, 5'd20, 5'd22}) && op1[XLEN-1];
    assign sb       = (op inside {5'd17, 5'd20, 5'd22}) && op2[XLEN-1];
    assign a_abs    = sa ? -op1 : op1;
    assign b_abs    = sb ? -op2 : op2;
    // a negative signed multiplier carries weight -2^(XLEN-1) in its top bit
    assign addend   = (cnt == '0 && sb) ? -mcand : mcand;
    assign acc_next = mplier[0] ? acc + addend : acc;
    assign mul_res  = (op[1:0] == 2'b00) ? acc_next[XLEN-1:0] : acc_next[2*XLEN-1:XLEN];
    // divide reuses acc as remainder, mplier as dividend/quotient, mcand as divisor
    assign rtry     = {acc[XLEN-1:0], mplier[XLEN-1]};
    assign ge       = rtry >= {1'b0, mcand[XLEN-1:0]};
    assign rsub     = rtry[XLEN-1:0] - mcand[XLEN-1:0];
    assign q_next   = {mplier[XLEN-2:0], ge};
    assign r_next   = ge ? rsub : rtry[XLEN-1:0];
    assign neg_q    = (sa ^ sb) && (op2 != '0);
    assign div_res  = op[1] ? (sa ? -r_next : r_next) : (neg_q ? -q_next : q_next);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            io.out_valid  <= 1'b0;
            io.alu_result <= '0;
            cnt           <= '0;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            op1           <= '0;
            op2           <= '0;
            pc_r          <= '0;
            op            <= '0;
        end else if (io.flush) begin
            state        <= IDLE;
            io.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (io.in_valid) begin
                    op1   <= io.rs1_data;
                    op2   <= io.alu_src ? io.imm : io.rs2_data;
                    pc_r  <= io.pc;
                    op    <= io.alu_op;
                    state <= EXEC;
                end
                EXEC: if (op[4:3] == 2'b10) begin
                    cnt <= SHW'(XLEN - 1);
                    acc <= '0;
                    if (op[2]) begin
                        mcand  <= {{XLEN{1'b0}}, b_abs};
                        mplier <= a_abs;
                        state  <= DIV;
                    end else begin
                        mcand  <= {{XLEN{sa}}, op1};
                        mplier <= op2;
                        state  <= MUL;
                    end
                end else begin
                    io.alu_result <= alu;
                    io.out_valid  <= 1'b1;
                    state         <= DONE;
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - SHW'(1);
                    if (cnt == '0) begin
                        io.alu_result <= mul_res;
                        io.out_valid  <= 1'b1;
                        state         <= DONE;
                    end
                end
                DIV: begin
                    acc    <= {{XLEN{1'b0}}, r_next};
                    mplier <= q_next;
                    cnt    <= cnt - SHW'(1);
                    if (cnt == '0) begin
                        io.alu_result <= div_res;
                        io.out_valid  <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: if (io.out_ready) begin
                    io.out_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
